serial_frame_rx: RTL and testbench

Serial frame receiver that sits directly downstream of the 4-bit serial shift/delay chain and consumes its `serial_out` bit stream, one bit per clock. It detects a start bit, shifts in a fixed-width data word LSB first, checks an optional even-parity bit and the stop bit, and then presents the word on a parallel output. The output is held in a one-deep valid/ready holding register. Framing, parity and overrun conditions are reported alongside the word.

---
 rtl/serial_frame_rx.sv | 157 +++++++++++++++
 tb/tb_serial_frame_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver with parity/stop checking and a one-deep valid/ready output
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   serial_in   in   serial line, one bit per clock, idles high
//   data_out    out  received word, first-received bit in bit 0
//   data_valid  out  data_out/parity_err hold an unconsumed word
//   data_ready  in   consumer accepts the word when data_valid is also 1
//   parity_err  out  even-parity mismatch for the held word
//   frame_err   out  one-cycle pulse when a stop bit is sampled low
//   overrun     out  sticky; a good frame was dropped because the holding register was full
//   busy        out  receiver is anywhere but IDLE
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DATA      = 3'd1,
        S_PARITY    = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_shift;
    logic              par_acc;
    logic              frame_perr;

    logic              start_det;
    logic              good_stop;
    logic              bad_stop;
    logic              hold_free;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!serial_in) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                state_nxt = S_STOP;
            end
            S_STOP: begin
                state_nxt = serial_in ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (serial_in) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output / strobe decode
    always_comb begin
        busy      = (state != S_IDLE);
        start_det = (state == S_IDLE) && !serial_in;
        good_stop = (state == S_STOP) && serial_in;
        bad_stop  = (state == S_STOP) && !serial_in;
    end

    // New bits enter at the MSB and move right, so after DATA_W shifts the
    // first-received bit sits in bit 0.
    always_comb begin
        shreg_shift             = shreg >> 1;
        shreg_shift[DATA_W-1]   = serial_in;
    end

    // Holding register can take a new word if empty or being drained this edge.
    assign hold_free = !data_valid || data_ready;

    // Datapath and holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            frame_perr <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= bad_stop;

            if (start_det) begin
                bit_cnt    <= '0;
                par_acc    <= 1'b0;
                frame_perr <= 1'b0;
            end

            if (state == S_DATA) begin
                shreg   <= shreg_shift;
                bit_cnt <= bit_cnt + 1'b1;
                par_acc <= par_acc ^ serial_in;
            end

            if (state == S_PARITY) begin
                frame_perr <= par_acc ^ serial_in;
            end

            if (good_stop) begin
                if (hold_free) begin
                    data_out   <= shreg;
                    parity_err <= frame_perr;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx with a frame-level reference model
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Per-bit stimulus stream and the frame-level events the bench scheduled into it.
    // ev: 0 none, 1 good stop sampled, 2 bad stop sampled.
    bit         b_q[$];
    bit         rdy_q[$];
    bit         rst_q[$];
    bit         busy_q[$];
    int         ev_q[$];
    logic [7:0] w_q[$];
    bit         pe_q[$];
    bit         cur_rdy;
    bit         rand_rdy;

    localparam int LOGN = 4096;
    logic [7:0] lg_data  [LOGN];
    bit         lg_valid [LOGN];
    bit         lg_perr  [LOGN];
    bit         lg_ferr  [LOGN];
    bit         lg_ovr   [LOGN];
    bit         lg_busy  [LOGN];

    logic [7:0] m_data;
    bit         m_valid, m_perr, m_ferr, m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit b, input bit rst, input int ev, input logic [7:0] w,
                        input bit pe, input bit bsy);
        b_q.push_back(b);
        rst_q.push_back(rst);
        ev_q.push_back(ev);
        w_q.push_back(w);
        pe_q.push_back(pe);
        busy_q.push_back(bsy);
        rdy_q.push_back(rand_rdy ? bit'($urandom_range(0, 1)) : cur_rdy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    endtask

    // Line held low after a bad stop, then one high bit that releases the receiver.
    task automatic low_then_high(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        push(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic add_frame(input logic [7:0] w, input bit pbit, input bit stop, output int s);
        bit pe;
        s = b_q.size();
        push(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) push(w[i], 1'b0, 0, 8'h00, 1'b0, 1'b1);
        push(pbit, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        pe = (^w) ^ pbit;
        if (stop) push(1'b1, 1'b0, 1, w, pe, 1'b0);
        else      push(1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic start_scenario(input bit rdy);
        b_q.delete(); rdy_q.delete(); rst_q.delete(); busy_q.delete();
        ev_q.delete(); w_q.delete(); pe_q.delete();
        cur_rdy  = rdy;
        rand_rdy = 1'b0;
        push(1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic run();
        for (int i = 0; i < b_q.size(); i++) begin
            @(negedge clk);
            serial_in  = b_q[i];
            data_ready = rdy_q[i];
            reset      = rst_q[i];
            @(posedge clk);
            #1;
            if (rst_q[i]) begin
                m_data = 8'h00; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
            end else begin
                m_ferr = (ev_q[i] == 2);
                if (ev_q[i] == 1) begin
                    if (!m_valid || rdy_q[i]) begin
                        m_data = w_q[i]; m_perr = pe_q[i]; m_valid = 1;
                    end else begin
                        m_ovr = 1;
                    end
                end else if (m_valid && rdy_q[i]) begin
                    m_valid = 0;
                end
            end
            check("data_valid", data_valid, m_valid);
            check("data_out", data_out, m_data);
            if (m_valid) check("parity_err", parity_err, m_perr);
            check("frame_err", frame_err, m_ferr);
            check("overrun", overrun, m_ovr);
            check("busy", busy, busy_q[i]);
            if (i < LOGN) begin
                lg_data[i] = data_out; lg_valid[i] = data_valid; lg_perr[i] = parity_err;
                lg_ferr[i] = frame_err; lg_ovr[i] = overrun; lg_busy[i] = busy;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        int s, s2, r;

        // Single frame 0xA5, good parity
        start_scenario(1'b1);
        idle(3);
        add_frame(8'hA5, 1'b0, 1'b1, s);
        idle(3);
        run();
        check("reset_valid", lg_valid[0], 1'b0);
        check("reset_data", lg_data[0], 8'h00);
        check("reset_busy", lg_busy[0], 1'b0);
        check("single_pre_valid", lg_valid[s+9], 1'b0);
        check("single_valid", lg_valid[s+10], 1'b1);
        check("single_data", lg_data[s+10], 8'hA5);
        check("single_perr", lg_perr[s+10], 1'b0);
        check("single_pulse", lg_valid[s+11], 1'b0);

        // Same frame, parity bit flipped
        start_scenario(1'b1);
        idle(2);
        add_frame(8'hA5, 1'b1, 1'b1, s);
        idle(2);
        run();
        check("perr_data", lg_data[s+10], 8'hA5);
        check("perr_flag", lg_perr[s+10], 1'b1);

        // Framing error, line low 5 cycles, then 0x81
        start_scenario(1'b1);
        idle(2);
        add_frame(8'h3C, 1'b0, 1'b0, s);
        low_then_high(5);
        add_frame(8'h81, 1'b0, 1'b1, s2);
        idle(2);
        run();
        check("ferr_pulse", lg_ferr[s+10], 1'b1);
        check("ferr_single", lg_ferr[s+11], 1'b0);
        check("ferr_no_valid", lg_valid[s+10], 1'b0);
        check("ferr_busy_low", lg_busy[s+15], 1'b1);
        check("ferr_next_data", lg_data[s2+10], 8'h81);
        check("ferr_next_valid", lg_valid[s2+10], 1'b1);

        // Back-to-back with backpressure
        start_scenario(1'b0);
        idle(2);
        add_frame(8'h11, 1'b0, 1'b1, s);
        add_frame(8'h22, 1'b0, 1'b1, s2);
        idle(3);
        cur_rdy = 1'b1;
        r = b_q.size();
        idle(1);
        cur_rdy = 1'b0;
        idle(2);
        run();
        check("bp_ovr_before", lg_ovr[s2+9], 1'b0);
        check("bp_ovr_set", lg_ovr[s2+10], 1'b1);
        check("bp_hold_data", lg_data[s2+10], 8'h11);
        check("bp_hold_valid", lg_valid[s2+10], 1'b1);
        check("bp_consumed", lg_valid[r], 1'b0);
        check("bp_keep_data", lg_data[r], 8'h11);

        // Consume and commit on the same edge
        start_scenario(1'b0);
        idle(2);
        add_frame(8'h11, 1'b0, 1'b1, s);
        idle(2);
        add_frame(8'h22, 1'b0, 1'b1, s2);
        rdy_q[s2+10] = 1'b1;
        idle(2);
        run();
        check("sim_data", lg_data[s2+10], 8'h22);
        check("sim_valid", lg_valid[s2+10], 1'b1);
        check("sim_ovr", lg_ovr[s2+10], 1'b0);

        // Reset mid-frame with a word held
        start_scenario(1'b0);
        idle(1);
        add_frame(8'h33, 1'b0, 1'b1, s);
        idle(1);
        push(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        push(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        push(1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        push(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        push(1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1);
        r = b_q.size();
        push(1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0);
        cur_rdy = 1'b1;
        idle(2);
        add_frame(8'h5A, 1'b0, 1'b1, s2);
        idle(2);
        run();
        check("rst_held_before", lg_valid[r-1], 1'b1);
        check("rst_valid", lg_valid[r], 1'b0);
        check("rst_data", lg_data[r], 8'h00);
        check("rst_busy", lg_busy[r], 1'b0);
        check("rst_next_data", lg_data[s2+10], 8'h5A);
        check("rst_next_valid", lg_valid[s2+10], 1'b1);

        // Random frames, gaps, parity, framing errors and ready
        start_scenario(1'b1);
        rand_rdy = 1'b1;
        for (int f = 0; f < 60; f++) begin
            logic [7:0] w;
            bit pb, good;
            w    = 8'($urandom);
            pb   = ($urandom_range(0, 3) == 0) ? ~(^w) : (^w);
            good = ($urandom_range(0, 5) != 0);
            idle($urandom_range(0, 3));
            add_frame(w, pb, good, s);
            if (!good) low_then_high($urandom_range(0, 4));
        end
        idle(4);
        run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
